fifo_rd_ctrl: RTL and testbench

- Read-domain controller for the async FIFO.
- Owns the read pointer and sequences reads from the synchronous-read dual-port RAM.
- Presents the data as a first-word-fall-through valid/ready stream.
- Exports the registered Gray read pointer for synchronisation into the write domain.
- Sits between the write-pointer synchroniser (input) and the consumer (output). It replaces ad-hoc empty logic with a fully sequenced read path.

---
 rtl/fifo_rd_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO: owns the read pointer, drives the
// synchronous-read RAM and presents a first-word-fall-through valid/ready stream.
module fifo_rd_ctrl #(
  parameter int unsigned PtrWidth  = 2,
  parameter int unsigned DataWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PtrWidth:0]     i_wr_gray_ptr_sync,
  output logic                  o_mem_ren,
  output logic [PtrWidth-1:0]   o_mem_raddr,
  input  logic [DataWidth-1:0]  i_mem_rdata,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DataWidth-1:0]  o_rd_data,
  output logic [PtrWidth:0]     o_rd_gray_ptr,
  output logic                  o_empty,
  output logic [PtrWidth+1:0]   o_level
);

  localparam int unsigned PW = PtrWidth + 1;
  localparam int unsigned LW = PtrWidth + 2;

  logic [PW-1:0]        r_rd_bin_ptr;
  logic [PW-1:0]        r_rd_gray_ptr;
  logic                 r_pend;
  logic                 r_out_valid;
  logic                 r_skid_valid;
  logic [DataWidth-1:0] r_out_data;
  logic [DataWidth-1:0] r_skid_data;

  logic [PW-1:0]        w_wr_bin_sync;
  logic [PW-1:0]        w_rd_bin_next;
  logic [PW-1:0]        w_ptr_diff;
  logic [1:0]           w_occ;
  logic                 w_ram_empty;
  logic                 w_pop;
  logic                 w_ren;
  logic                 w_out_free;

  // Gray-to-binary of the synchronised write pointer
  always_comb begin
    w_wr_bin_sync         = '0;
    w_wr_bin_sync[PW-1]   = i_wr_gray_ptr_sync[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      w_wr_bin_sync[i] = w_wr_bin_sync[i+1] ^ i_wr_gray_ptr_sync[i];
    end
  end

  assign w_ram_empty   = (r_rd_bin_ptr == w_wr_bin_sync);
  assign w_pop         = r_out_valid & i_rd_ready;
  assign w_occ         = 2'(r_pend) + 2'(r_out_valid) + 2'(r_skid_valid);
  assign w_ren         = rst_n & ~w_ram_empty & ((w_occ - 2'(w_pop)) < 2'd2);
  assign w_rd_bin_next = r_rd_bin_ptr + PW'(w_ren);
  assign w_ptr_diff    = w_wr_bin_sync - r_rd_bin_ptr;
  // Output slot can accept a word when empty or being drained this cycle
  assign w_out_free    = ~r_out_valid | i_rd_ready;

  assign o_mem_ren     = w_ren;
  assign o_mem_raddr   = r_rd_bin_ptr[PtrWidth-1:0];
  assign o_rd_valid    = r_out_valid;
  assign o_rd_data     = r_out_data;
  assign o_rd_gray_ptr = r_rd_gray_ptr;
  assign o_empty       = ~r_out_valid;
  assign o_level       = rst_n ? (LW'(w_ptr_diff) + LW'(w_occ)) : '0;

  // Read pointer and its registered Gray copy for the write domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bin_ptr  <= '0;
      r_rd_gray_ptr <= '0;
      r_pend        <= 1'b0;
    end else begin
      r_rd_bin_ptr  <= w_rd_bin_next;
      r_rd_gray_ptr <= w_rd_bin_next ^ (w_rd_bin_next >> 1);
      r_pend        <= w_ren;
    end
  end

  // Output register plus skid: skid always drains first to keep FIFO order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        if (r_pend) begin
          r_skid_data <= i_mem_rdata;
        end else begin
          r_skid_valid <= 1'b0;
        end
      end else if (r_pend) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_mem_rdata;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (r_pend) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: the bench plays writer, RAM and consumer,
// and checks the stream and pointer outputs against a word-count model.
module tb_fifo_rd_ctrl;

  localparam int unsigned PtrWidth  = 2;
  localparam int unsigned DataWidth = 8;
  localparam int unsigned Depth     = 1 << PtrWidth;

  logic                 clk;
  logic                 rst_n;
  logic [PtrWidth:0]    i_wr_gray_ptr_sync;
  logic                 o_mem_ren;
  logic [PtrWidth-1:0]  o_mem_raddr;
  logic [DataWidth-1:0] i_mem_rdata;
  logic                 o_rd_valid;
  logic                 i_rd_ready;
  logic [DataWidth-1:0] o_rd_data;
  logic [PtrWidth:0]    o_rd_gray_ptr;
  logic                 o_empty;
  logic [PtrWidth+1:0]  o_level;

  fifo_rd_ctrl #(.PtrWidth(PtrWidth), .DataWidth(DataWidth)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_wr_gray_ptr_sync (i_wr_gray_ptr_sync),
    .o_mem_ren          (o_mem_ren),
    .o_mem_raddr        (o_mem_raddr),
    .i_mem_rdata        (i_mem_rdata),
    .o_rd_valid         (o_rd_valid),
    .i_rd_ready         (i_rd_ready),
    .o_rd_data          (o_rd_data),
    .o_rd_gray_ptr      (o_rd_gray_ptr),
    .o_empty            (o_empty),
    .o_level            (o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] exp_q [$];
  int wr_cnt  = 0;
  int iss_cnt = 0;
  int pop_cnt = 0;
  logic                 hold_prev = 1'b0;
  logic [DataWidth-1:0] data_prev = '0;

  function automatic int gray_of(int b);
    int m;
    m = b % (2 * Depth);
    return m ^ (m >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM model
  always @(posedge clk) begin
    if (o_mem_ren) i_mem_rdata <= mem[o_mem_raddr];
  end

  // Monitor: reference model of issue/level/pointer plus in-order data scoreboard
  always @(negedge clk) begin
    int  occ;
    int  popn;
    bit  exp_ren;
    if (!rst_n) begin
      chk("rst_ren", int'(o_mem_ren), 0);
      chk("rst_valid", int'(o_rd_valid), 0);
      chk("rst_empty", int'(o_empty), 1);
      chk("rst_level", int'(o_level), 0);
      chk("rst_gray", int'(o_rd_gray_ptr), 0);
      iss_cnt   = 0;
      pop_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      occ     = iss_cnt - pop_cnt;
      popn    = int'(o_rd_valid & i_rd_ready);
      exp_ren = (wr_cnt != iss_cnt) && ((occ - popn) < 2);
      chk("ren", int'(o_mem_ren), int'(exp_ren));
      if (exp_ren) chk("raddr", int'(o_mem_raddr), iss_cnt % Depth);
      chk("gray_ptr", int'(o_rd_gray_ptr), gray_of(iss_cnt));
      chk("level", int'(o_level), wr_cnt - pop_cnt);
      chk("empty", int'(o_empty), int'(!o_rd_valid));
      if (hold_prev) begin
        chk("hold_valid", int'(o_rd_valid), 1);
        chk("hold_data", int'(o_rd_data), int'(data_prev));
      end
      if (popn != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", int'(o_rd_data), -1);
        end else begin
          chk("data", int'(o_rd_data), int'(exp_q.pop_front()));
        end
        pop_cnt++;
      end
      if (exp_ren) iss_cnt++;
      hold_prev = o_rd_valid & ~i_rd_ready;
      data_prev = o_rd_data;
    end
  end

  task automatic put_word(logic [DataWidth-1:0] d);
    mem[wr_cnt % Depth] = d;
    exp_q.push_back(d);
    wr_cnt++;
    i_wr_gray_ptr_sync = (PtrWidth+1)'(gray_of(wr_cnt));
  endtask

  task automatic write_step(int n);
    @(posedge clk); #2;
    for (int k = 0; k < n; k++) put_word(DataWidth'($urandom));
  endtask

  // mode 0: ready high, 1: ready toggling, 2: random ready and bursty writes
  task automatic run(int nwords, int mode);
    int left;
    int n;
    int space;
    left = nwords;
    for (int c = 0; c < 2000 && left > 0; c++) begin
      @(posedge clk); #2;
      if (mode == 0) i_rd_ready = 1'b1;
      else if (mode == 1) i_rd_ready = ~i_rd_ready;
      else i_rd_ready = 1'($urandom);
      space = int'(Depth) - (wr_cnt - pop_cnt);
      n = (mode == 2) ? int'($urandom_range(0, 2)) : 1;
      if (n > space) n = space;
      if (n > left) n = left;
      for (int k = 0; k < n; k++) put_word(DataWidth'($urandom));
      left -= n;
    end
    chk("run_all_written", left, 0);
  endtask

  task automatic drain();
    int c;
    @(posedge clk); #2;
    i_rd_ready = 1'b1;
    for (c = 0; c < 200 && pop_cnt != wr_cnt; c++) @(posedge clk);
    chk("drain_timeout", int'(pop_cnt == wr_cnt), 1);
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_empty", int'(o_empty), 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    i_rd_ready = 1'b0;
    for (int k = 0; k < int'(Depth); k++) mem[k] = '0;
    // Reset with a non-zero write pointer: two words waiting
    i_wr_gray_ptr_sync = '0;
    put_word(8'h11);
    put_word(8'h22);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    drain();

    // Single word latency: ren same cycle, valid two cycles later
    i_rd_ready = 1'b1;
    write_step(1);
    @(negedge clk);
    chk("lat_ren", int'(o_mem_ren), 1);
    chk("lat_level0", int'(o_level), 1);
    @(negedge clk);
    chk("lat_valid1", int'(o_rd_valid), 0);
    @(negedge clk);
    chk("lat_valid2", int'(o_rd_valid), 1);
    drain();

    // Backpressure: only two reads issued, level counts all four
    i_rd_ready = 1'b0;
    write_step(4);
    repeat (4) @(negedge clk);
    chk("bp_level", int'(o_level), 4);
    chk("bp_ren", int'(o_mem_ren), 0);
    chk("bp_issued", iss_cnt - pop_cnt, 2);
    drain();

    // Streaming across the pointer wrap, ready toggling, then random traffic
    run(8, 0);
    drain();
    i_rd_ready = 1'b0;
    run(6, 1);
    drain();
    run(300, 2);
    drain();

    // Reset while a read is in flight and a word is held at the output
    i_rd_ready = 1'b0;
    write_step(2);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(o_rd_valid), 0);
    chk("mid_rst_gray", int'(o_rd_gray_ptr), 0);
    chk("mid_rst_level", int'(o_level), 0);
    exp_q.delete();
    wr_cnt = 0;
    i_wr_gray_ptr_sync = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    write_step(0);
    put_word(8'hA5);
    drain();
    run(20, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
